// File: rtl/testutil_console_pkg.sv
// Shared definitions for the memory-mapped character console: register
// offsets, STATUS bit positions and the end-of-test character code.
package testutil_console_pkg;

    // Register offsets as decoded from dev_addr_i[3:2]
    typedef enum logic [1:0] {
        TxData  = 2'd0,
        Status  = 2'd1,
        Ctrl    = 2'd2,
        DropCnt = 2'd3
    } console_reg_e;

    // STATUS register layout
    localparam int StatusFullBit  = 0;
    localparam int StatusEmptyBit = 1;
    localparam int StatusLvlLsb   = 8;
    localparam int StatusEotBit   = 16;

    // ASCII EOT, used as the end-of-test marker byte
    localparam logic [7:0] EotChar = 8'h04;

endpackage

// File: rtl/testutil_console_fifo.sv
// Byte-wide synchronous FIFO with a separate level counter. The head entry
// is presented combinationally so a pushed byte is visible the next cycle.
// Storage is not reset; only pointers and level are.
module testutil_console_fifo #(
    parameter int Depth = 16,
    parameter int LvlW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [7:0]      wdata_i,
    output logic [7:0]      rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [LvlW-1:0] level_o
);
    localparam int PtrW = $clog2(Depth);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            push_ok, pop_ok;

    // Guard against overflow/underflow even if the caller misbehaves
    always_comb begin
        push_ok = push_i & ~full_o;
        pop_ok  = pop_i & ~empty_o;
        wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop_ok ? rptr_q + PtrW'(1) : rptr_q;
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LvlW'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LvlW'(1);
        end
    end

    // Character storage; deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (level_q == LvlW'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/testutil_console.sv
// Memory-mapped character console: bus register decode, one-cycle response
// registers, drain handshake with hold-until-accepted, saturating drop count.
// Optional sticky end-of-test detection is built when
// TESTUTIL_CONSOLE_EOT_DETECT_EN is defined; otherwise eot_o is tied low.
module testutil_console
    import testutil_console_pkg::*;
#(
    parameter int FifoDepth = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [31:0] dev_addr_i,
    input  logic [31:0] dev_wdata_i,
    input  logic [3:0]  dev_be_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        eot_o
);
    localparam int LvlW = $clog2(FifoDepth + 1);

    console_reg_e    reg_sel;
    logic            addr_err;
    logic            wr_txdata, wr_ctrl, wr_dropcnt;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_rdata;
    logic [LvlW-1:0] fifo_level;
    logic            drain_en_q, drain_en_d;
    logic            hold_q, hold_d;
    logic [15:0]     dropcnt_q, dropcnt_d;
    logic            rvalid_q, err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            eot_flag;
    logic            unused_bits;

    assign unused_bits = ^{dev_wdata_i[31:8], dev_be_i[3:1]};

    assign reg_sel    = console_reg_e'(dev_addr_i[3:2]);
    assign addr_err   = (dev_addr_i[1:0] != 2'b00) | (dev_addr_i[31:4] != 28'd0);
    assign wr_txdata  = dev_req_i & dev_we_i & ~addr_err & (reg_sel == TxData)  & dev_be_i[0];
    assign wr_ctrl    = dev_req_i & dev_we_i & ~addr_err & (reg_sel == Ctrl)    & dev_be_i[0];
    assign wr_dropcnt = dev_req_i & dev_we_i & ~addr_err & (reg_sel == DropCnt) & dev_be_i[0];

    // Full is judged on pre-pop state, so a push into a full FIFO is dropped
    assign fifo_push = wr_txdata & ~fifo_full;

    testutil_console_fifo #(
        .Depth (FifoDepth),
        .LvlW  (LvlW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (dev_wdata_i[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Drain: once offered, a byte stays offered until accepted
    always_comb begin
        char_valid_o = ~fifo_empty & (drain_en_q | hold_q);
        fifo_pop     = char_valid_o & char_ready_i;
        hold_d       = hold_q;
        if (char_valid_o && !char_ready_i) begin
            hold_d = 1'b1;
        end else if (fifo_pop || fifo_empty) begin
            hold_d = 1'b0;
        end
    end
    assign char_data_o = fifo_rdata;

    // Control and drop-count next state
    always_comb begin
        drain_en_d = wr_ctrl ? dev_wdata_i[0] : drain_en_q;
        dropcnt_d  = dropcnt_q;
        if (wr_dropcnt) begin
            dropcnt_d = 16'd0;
        end else if (wr_txdata && fifo_full && (dropcnt_q != 16'hFFFF)) begin
            dropcnt_d = dropcnt_q + 16'd1;
        end
    end

    // Read mux and error response, sampled on pre-update state
    always_comb begin
        rdata_d = 32'd0;
        err_d   = dev_req_i & addr_err;
        if (dev_req_i && !dev_we_i && !addr_err) begin
            case (reg_sel)
                Status: begin
                    rdata_d[StatusFullBit]       = fifo_full;
                    rdata_d[StatusEmptyBit]      = fifo_empty;
                    rdata_d[StatusLvlLsb +: 8]   = 8'(fifo_level);
                    rdata_d[StatusEotBit]        = eot_flag;
                end
                Ctrl:    rdata_d[0]     = drain_en_q;
                DropCnt: rdata_d[15:0]  = dropcnt_q;
                default: rdata_d        = 32'd0;
            endcase
        end
    end

    // Control, drain and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drain_en_q <= 1'b1;
            hold_q     <= 1'b0;
            dropcnt_q  <= 16'd0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            drain_en_q <= drain_en_d;
            hold_q     <= hold_d;
            dropcnt_q  <= dropcnt_d;
            rvalid_q   <= dev_req_i;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dev_rvalid_o = rvalid_q;
    assign dev_err_o    = err_q;
    assign dev_rdata_o  = rdata_q;

`ifdef TESTUTIL_CONSOLE_EOT_DETECT_EN
    logic eot_q, eot_d;
    // EOT is flagged on the push request itself, even when the byte is dropped
    assign eot_d = eot_q | (wr_txdata & (dev_wdata_i[7:0] == EotChar));

    // Sticky end-of-test flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eot_q <= 1'b0;
        end else begin
            eot_q <= eot_d;
        end
    end
    assign eot_flag = eot_q;
`else
    assign eot_flag = 1'b0;
`endif

    assign eot_o = eot_flag;

endmodule

// File: tb/tb_testutil_console.sv
// Bench for testutil_console: directed steps followed by randomized traffic,
// each cycle compared against a queue-based behavioural model.
module tb_testutil_console;
    localparam int Depth = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dev_req_i, dev_we_i;
    logic [31:0] dev_addr_i, dev_wdata_i;
    logic [3:0]  dev_be_i;
    logic        dev_rvalid_o, dev_err_o;
    logic [31:0] dev_rdata_o;
    logic        char_valid_o, char_ready_i, eot_o;
    logic [7:0]  char_data_o;

    always #5 clk_i = ~clk_i;

    testutil_console #(.FifoDepth(Depth)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dev_req_i    (dev_req_i),
        .dev_we_i     (dev_we_i),
        .dev_addr_i   (dev_addr_i),
        .dev_wdata_i  (dev_wdata_i),
        .dev_be_i     (dev_be_i),
        .dev_rvalid_o (dev_rvalid_o),
        .dev_rdata_o  (dev_rdata_o),
        .dev_err_o    (dev_err_o),
        .char_valid_o (char_valid_o),
        .char_data_o  (char_data_o),
        .char_ready_i (char_ready_i),
        .eot_o        (eot_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model
    byte unsigned m_q[$];
    bit           m_drain   = 1'b1;
    bit           m_offered = 1'b0;
    bit           m_eot     = 1'b0;
    int           m_drop    = 0;
    bit           exp_rvalid = 1'b0;
    bit           exp_err    = 1'b0;
    logic [31:0]  exp_rdata  = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_drain    = 1'b1;
        m_offered  = 1'b0;
        m_eot      = 1'b0;
        m_drop     = 0;
        exp_rvalid = 1'b0;
        exp_err    = 1'b0;
        exp_rdata  = 32'd0;
    endfunction

    // One clock cycle: check current outputs, apply inputs, advance model
    task automatic step(input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input bit ready);
        bit          valid, pop, aerr, full, push_req;
        int          lvl;
        logic [31:0] rd;
        chk("rvalid", {31'd0, dev_rvalid_o}, {31'd0, exp_rvalid});
        chk("rdata", dev_rdata_o, exp_rdata);
        chk("err", {31'd0, dev_err_o}, {31'd0, exp_err});
        chk("eot", {31'd0, eot_o}, {31'd0, m_eot});
        valid = (m_q.size() > 0) && (m_drain || m_offered);
        chk("char_valid", {31'd0, char_valid_o}, {31'd0, valid});
        if (valid) chk("char_data", {24'd0, char_data_o}, {24'd0, m_q[0]});

        dev_req_i    = req;
        dev_we_i     = we;
        dev_addr_i   = addr;
        dev_wdata_i  = wdata;
        dev_be_i     = be;
        char_ready_i = ready;

        aerr = (addr[1:0] != 2'b00) || (addr[31:4] != 28'd0);
        lvl  = m_q.size();
        full = (lvl == Depth);
        rd   = 32'd0;
        if (req && !we && !aerr) begin
            case (addr[3:2])
                2'd1:    rd = {15'd0, m_eot, lvl[7:0], 6'd0, (lvl == 0), full};
                2'd2:    rd = {31'd0, m_drain};
                2'd3:    rd = {16'd0, m_drop[15:0]};
                default: rd = 32'd0;
            endcase
        end
        pop      = valid && ready;
        push_req = req && we && !aerr && (addr[3:2] == 2'd0) && be[0];
        if (pop) void'(m_q.pop_front());
        if (push_req) begin
            if (full) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                m_q.push_back(wdata[7:0]);
            end
`ifdef TESTUTIL_CONSOLE_EOT_DETECT_EN
            if (wdata[7:0] == 8'h04) m_eot = 1'b1;
`endif
        end
        if (req && we && !aerr && addr[3:2] == 2'd2 && be[0]) m_drain = wdata[0];
        if (req && we && !aerr && addr[3:2] == 2'd3 && be[0]) m_drop = 0;
        m_offered  = valid && !ready;
        exp_rvalid = req;
        exp_err    = req && aerr;
        exp_rdata  = rd;
        if (req) $display("txn t=%0t %s addr=%h wdata=%h be=%h expect_rdata=%h expect_err=%0d",
                          $time, we ? "WR" : "RD", addr, wdata, be, rd, exp_err);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit ready = 1'b1);
        step(1'b1, 1'b1, addr, data, 4'hF, ready);
    endtask
    task automatic rd(input logic [31:0] addr, input bit ready = 1'b1);
        step(1'b1, 1'b0, addr, 32'd0, 4'hF, ready);
    endtask
    task automatic idle(input bit ready = 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, ready);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  b;
        int          op, rp;
        bit          rdy;

        rst_i = 1'b1; dev_req_i = 1'b0; dev_we_i = 1'b0; dev_addr_i = '0;
        dev_wdata_i = '0; dev_be_i = '0; char_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_rvalid", {31'd0, dev_rvalid_o}, 32'd0);
        chk("reset_char_valid", {31'd0, char_valid_o}, 32'd0);
        rst_i = 1'b0;

        // 1: reset state
        rd(32'h4);
        chk("status_after_reset", dev_rdata_o, 32'h0000_0002);
        rd(32'h8);
        chk("ctrl_after_reset", dev_rdata_o, 32'h0000_0001);

        // 2: buffer with drain off, then drain
        wr(32'h8, 32'h0);
        wr(32'h0, 32'h41); wr(32'h0, 32'h42); wr(32'h0, 32'h43);
        rd(32'h4);
        chk("status_level3", dev_rdata_o, 32'h0000_0300);
        chk("no_drain_valid", {31'd0, char_valid_o}, 32'd0);
        wr(32'h8, 32'h1);
        chk("first_byte", {24'd0, char_data_o}, 32'h41);
        repeat (4) idle();

        // 3: overflow and drop count
        wr(32'h8, 32'h0);
        for (int i = 0; i < 17; i++) wr(32'h0, 32'h60 + i);
        rd(32'h4);
        chk("status_full", dev_rdata_o, 32'h0000_1001);
        rd(32'hC);
        chk("dropcnt_one", dev_rdata_o, 32'h0000_0001);
        step(1'b1, 1'b1, 32'h0, 32'h99, 4'h0, 1'b1);   // be[0]=0: no push
        step(1'b1, 1'b1, 32'hC, 32'h0, 4'h1, 1'b1);
        rd(32'hC);
        chk("dropcnt_cleared", dev_rdata_o, 32'h0000_0000);
        wr(32'h8, 32'h1);
        repeat (18) idle();

        // 4: hold while not ready, even after drain disabled
        wr(32'h0, 32'h55, 1'b0);
        idle(1'b0);
        wr(32'h8, 32'h0, 1'b0);
        chk("hold_valid", {31'd0, char_valid_o}, 32'd1);
        chk("hold_data", {24'd0, char_data_o}, 32'h55);
        idle(1'b0); idle(1'b0);
        idle(1'b1);
        chk("after_accept", {31'd0, char_valid_o}, 32'd0);
        wr(32'h8, 32'h1);

        // 5: bad addresses
        rd(32'h10);
        chk("bad_addr_err", {31'd0, dev_err_o}, 32'd1);
        chk("bad_addr_rdata", dev_rdata_o, 32'd0);
        rd(32'h5);
        wr(32'h12, 32'h0);
        wr(32'h20, 32'h0);
        rd(32'h4);

        // 6: EOT and reset mid-drain
        wr(32'h0, 32'h04, 1'b0);
`ifdef TESTUTIL_CONSOLE_EOT_DETECT_EN
        chk("eot_set", {31'd0, eot_o}, 32'd1);
`else
        chk("eot_tied", {31'd0, eot_o}, 32'd0);
`endif
        rd(32'h4, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 5; i++) wr(32'h0, 32'h30 + i, 1'b0);
        rd(32'h4, 1'b0);
        idle(1'b1);
        rst_i = 1'b1;
        #1;
        chk("rst_char_valid", {31'd0, char_valid_o}, 32'd0);
        chk("rst_rvalid", {31'd0, dev_rvalid_o}, 32'd0);
        chk("rst_eot", {31'd0, eot_o}, 32'd0);
        chk("rst_rdata", dev_rdata_o, 32'd0);
        dev_req_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd(32'h4);
        chk("status_after_midreset", dev_rdata_o, 32'h0000_0002);

        // Randomized traffic with alternating backpressure phases
        for (int n = 0; n < 800; n++) begin
            rp  = ((n / 100) % 2 == 0) ? 20 : 85;
            rdy = ($urandom_range(0, 99) < rp);
            op  = $urandom_range(0, 9);
            d   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (op)
                0, 1, 2, 3, 4: begin
                    if ($urandom_range(0, 15) == 0) d[7:0] = 8'h04;
                    step(1'b1, 1'b1, 32'h0, d, b, rdy);
                end
                5: rd(32'h4, rdy);
                6: step(1'b1, $urandom_range(0, 1) == 1, 32'h8,
                        {31'd0, $urandom_range(0, 3) != 0}, b, rdy);
                7: step(1'b1, $urandom_range(0, 3) == 0, 32'hC, d, b, rdy);
                8: begin
                    if ($urandom_range(0, 1) == 1)
                        a = 32'($urandom_range(1, 3)) | (32'($urandom_range(0, 3)) << 2);
                    else
                        a = 32'h10 << $urandom_range(0, 27);
                    step(1'b1, $urandom_range(0, 1) == 1, a, d, b, rdy);
                end
                default: idle(rdy);
            endcase
        end
        wr(32'h8, 32'h1);
        repeat (Depth + 2) idle(1'b1);
        rd(32'h4);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
